seq_divider: RTL and testbench

Parametrised multi-cycle integer divider: radix-2 restoring division over `WIDTH` cycles, selectable signed (truncating) or unsigned mode. It adds a start/busy/done handshake, divide-by-zero detection, a correctly signed remainder, and results held stable until the next operation. It sits beside the datapath as a shared arithmetic unit, driven by a controlling FSM that pulses a start signal and waits for done.

---
 rtl/div_pkg.sv | 29 ++
 rtl/div_step.sv | 22 ++
 rtl/seq_divider.sv | 135 +++++++++++++
 tb/tb_seq_divider.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential radix-2 divider.
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } div_state_e;

  localparam int DIV_MAX_W = 64;
  localparam logic DBZ_FLAG = 1'b1;

  // Iteration counter only has to reach w-1.
  function automatic int cnt_width(input int w);
    return (w < 3) ? 1 : $clog2(w);
  endfunction

  // Quotient reported on divide-by-zero: all ones in the low w bits.
  function automatic logic [DIV_MAX_W-1:0] dbz_quotient(input int w);
    logic [DIV_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < DIV_MAX_W; i++) begin
      if (i < w) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit,
// subtract the divisor magnitude when it fits.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0] p_i,
  input  logic           bit_i,
  input  logic [WIDTH:0] dmag_i,
  output logic [WIDTH:0] p_o,
  output logic           q_o
);

  logic [WIDTH:0] shifted;
  logic           unused_p_msb;

  // P is always below the divisor magnitude, so its MSB is zero on entry.
  assign unused_p_msb = p_i[WIDTH];
  assign shifted      = {p_i[WIDTH-1:0], bit_i};
  assign q_o          = (shifted >= dmag_i);
  assign p_o          = q_o ? (shifted - dmag_i) : shifted;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned truncating divider with start/busy/done handshake.
// Results and divide-by-zero flag are held until the next operation completes.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start_Sig,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Done_Sig,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Div_By_Zero
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] DBZ_QUOT = WIDTH'(dbz_quotient(WIDTH));

  div_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [WIDTH:0] p_q, p_d;
  logic [WIDTH:0] dmag_q, dmag_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic           neg_quo_q, neg_quo_d;
  logic           neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic           dbz_q, dbz_d;

  logic           dvd_neg, dvs_neg;
  logic [WIDTH:0] step_p;
  logic           step_bit;

  assign dvd_neg = SIGNED && Dividend[WIDTH-1];
  assign dvs_neg = SIGNED && Divisor[WIDTH-1];

  div_step #(.WIDTH(WIDTH)) u_step (
    .p_i    (p_q),
    .bit_i  (a_q[WIDTH-1]),
    .dmag_i (dmag_q),
    .p_o    (step_p),
    .q_o    (step_bit)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    p_d       = p_q;
    dmag_d    = dmag_q;
    a_d       = a_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (Start_Sig) begin
          state_d   = S_CALC;
          cnt_d     = '0;
          p_d       = '0;
          // A WIDTH-bit unsigned magnitude holds even the most negative value.
          a_d       = dvd_neg ? (-Dividend) : Dividend;
          dmag_d    = {1'b0, (dvs_neg ? (-Divisor) : Divisor)};
          neg_quo_d = dvd_neg ^ dvs_neg;
          neg_rem_d = dvd_neg;
        end
      end
      S_CALC: begin
        if (dmag_q == '0) begin
          // No iterations done yet, so a_q still holds the dividend magnitude.
          quo_d   = DBZ_QUOT;
          rem_d   = neg_rem_q ? (-a_q) : a_q;
          dbz_d   = DBZ_FLAG;
          state_d = S_DONE;
        end else begin
          p_d   = step_p;
          a_d   = {a_q[WIDTH-2:0], step_bit};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        quo_d   = neg_quo_q ? (-a_q) : a_q;
        rem_d   = neg_rem_q ? (-p_q[WIDTH-1:0]) : p_q[WIDTH-1:0];
        dbz_d   = 1'b0;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      p_q       <= '0;
      dmag_q    <= '0;
      a_q       <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      p_q       <= p_d;
      dmag_q    <= dmag_d;
      a_q       <= a_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dbz_q     <= dbz_d;
    end
  end

  assign Busy        = (state_q != S_IDLE);
  assign Done_Sig    = (state_q == S_DONE);
  assign Quotient    = quo_q;
  assign Remainder   = rem_q;
  assign Div_By_Zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: signed 8-bit, unsigned 8-bit and unsigned 16-bit instances
// checked with a vector table, handshake corner sequences and random operands.
module tb_seq_divider;

  logic        CLK = 1'b0;
  logic        RST;
  logic [2:0]  start;
  logic [15:0] dvd, dvs;

  logic        busy0, busy1, busy2, done0, done1, done2, dbz0, dbz1, dbz2;
  logic [7:0]  q0, r0, q1, r1;
  logic [15:0] q2, r2;

  int          sel_r;
  logic [15:0] c_q, c_r;
  logic        c_busy, c_done, c_dbz;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [1:0]  sel;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        z;
    logic [4:0]  lat;
  } vec_t;

  vec_t vecs [12];

  always #5 CLK = ~CLK;

  seq_divider #(.WIDTH(8), .SIGNED(1'b1)) u_s8 (
    .CLK(CLK), .RST(RST), .Start_Sig(start[0]), .Dividend(dvd[7:0]), .Divisor(dvs[7:0]),
    .Busy(busy0), .Done_Sig(done0), .Quotient(q0), .Remainder(r0), .Div_By_Zero(dbz0));

  seq_divider #(.WIDTH(8), .SIGNED(1'b0)) u_u8 (
    .CLK(CLK), .RST(RST), .Start_Sig(start[1]), .Dividend(dvd[7:0]), .Divisor(dvs[7:0]),
    .Busy(busy1), .Done_Sig(done1), .Quotient(q1), .Remainder(r1), .Div_By_Zero(dbz1));

  seq_divider #(.WIDTH(16), .SIGNED(1'b0)) u_u16 (
    .CLK(CLK), .RST(RST), .Start_Sig(start[2]), .Dividend(dvd), .Divisor(dvs),
    .Busy(busy2), .Done_Sig(done2), .Quotient(q2), .Remainder(r2), .Div_By_Zero(dbz2));

  always_comb begin
    c_q = '0; c_r = '0; c_busy = 1'b0; c_done = 1'b0; c_dbz = 1'b0;
    case (sel_r)
      0: begin c_q = {8'h00, q0}; c_r = {8'h00, r0}; c_busy = busy0; c_done = done0; c_dbz = dbz0; end
      1: begin c_q = {8'h00, q1}; c_r = {8'h00, r1}; c_busy = busy1; c_done = done1; c_dbz = dbz1; end
      default: begin c_q = q2; c_r = r2; c_busy = busy2; c_done = done2; c_dbz = dbz2; end
    endcase
  end

  function automatic vec_t mk(input int sel, input int a, input int b, input int q,
                              input int r, input int z, input int lat);
    vec_t v;
    v.sel = 2'(sel); v.a = 16'(a); v.b = 16'(b); v.q = 16'(q); v.r = 16'(r);
    v.z = 1'(z); v.lat = 5'(lat);
    return v;
  endfunction

  // Truncating division from plain integer arithmetic on the operand values.
  function automatic void ref_div(input int w, input bit sg, input logic [15:0] a,
                                  input logic [15:0] b, output logic [15:0] q,
                                  output logic [15:0] r, output logic z);
    longint sa, sb;
    logic [15:0] mask;
    mask = (w == 16) ? 16'hFFFF : 16'h00FF;
    sa = longint'(a & mask);
    sb = longint'(b & mask);
    if (sg && a[w-1]) sa = sa - (longint'(1) << w);
    if (sg && b[w-1]) sb = sb - (longint'(1) << w);
    if (sb == 0) begin
      q = mask; r = a & mask; z = 1'b1;
    end else begin
      q = 16'(sa / sb) & mask; r = 16'(sa % sb) & mask; z = 1'b0;
    end
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; returns cycles from the accepting edge to Done_Sig.
  task automatic do_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] q, output logic [15:0] r, output logic z,
                       output int lat, output logic tail_ok);
    logic busy_e0;
    sel_r = sel;
    dvd = a; dvs = b;
    start = '0; start[sel] = 1'b1;
    @(posedge CLK); #1;
    busy_e0 = c_busy;
    start = '0; dvd = 16'($urandom); dvs = 16'($urandom);
    lat = 99;
    for (int n = 1; n <= 40; n++) begin
      @(posedge CLK); #1;
      if (c_done) begin lat = n; break; end
    end
    q = c_q; r = c_r; z = c_dbz;
    @(posedge CLK); #1;
    tail_ok = busy_e0 && !c_done && !c_busy;
  endtask

  initial begin
    logic [15:0] q, r, eq, er, mask;
    logic        z, ez, tail;
    int          lat, sel, w, bad_hold, seen;
    int          held [$];

    RST = 1'b1; start = '0; dvd = '0; dvs = '0; sel_r = 0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel_r = s; #1;
      chk($sformatf("reset%0d_q", s), c_q, 16'h0);
      chk($sformatf("reset%0d_r", s), c_r, 16'h0);
      chk($sformatf("reset%0d_flags", s), {13'h0, c_busy, c_done, c_dbz}, 16'h0);
    end
    @(posedge CLK); #1;

    vecs[0]  = mk(0, 100,   7,    'h0E, 2,    0, 9);
    vecs[1]  = mk(1, 200,   3,    66,   2,    0, 9);
    vecs[2]  = mk(2, 65535, 255,  257,  0,    0, 17);
    vecs[3]  = mk(0, 'h9C,  7,    'hF2, 'hFE, 0, 9);
    vecs[4]  = mk(0, 100,   'hF9, 'hF2, 'h02, 0, 9);
    vecs[5]  = mk(0, 'h9C,  'hF9, 'h0E, 'hFE, 0, 9);
    vecs[6]  = mk(0, 'h80,  'hFF, 'h80, 0,    0, 9);
    vecs[7]  = mk(0, 'h80,  1,    'h80, 0,    0, 9);
    vecs[8]  = mk(0, 5,     0,    'hFF, 5,    1, 1);
    vecs[9]  = mk(0, 'hFB,  0,    'hFF, 'hFB, 1, 1);
    vecs[10] = mk(1, 'hC8,  0,    'hFF, 'hC8, 1, 1);
    vecs[11] = mk(2, 200,   0,    'hFFFF, 200, 1, 1);

    for (int i = 0; i < 12; i++) begin
      do_op(int'(vecs[i].sel), vecs[i].a, vecs[i].b, q, r, z, lat, tail);
      chk($sformatf("vec%0d_q", i), q, vecs[i].q);
      chk($sformatf("vec%0d_r", i), r, vecs[i].r);
      chk($sformatf("vec%0d_dbz", i), {15'h0, z}, {15'h0, vecs[i].z});
      chk($sformatf("vec%0d_lat", i), 16'(lat), {11'h0, vecs[i].lat});
      chk($sformatf("vec%0d_tail", i), {15'h0, tail}, 16'h1);
    end

    // A second start mid-CALC must not disturb the running operation.
    sel_r = 0; dvd = 100; dvs = 7; start = 3'b001;
    @(posedge CLK); #1;
    start = '0;
    repeat (3) @(posedge CLK);
    #1 start = 3'b001; dvd = 50; dvs = 5;
    @(posedge CLK); #1;
    start = '0;
    lat = 99;
    for (int n = 5; n <= 40; n++) begin
      @(posedge CLK); #1;
      if (c_done) begin lat = n; break; end
    end
    chk("midstart_lat", 16'(lat), 16'd9);
    chk("midstart_q", c_q, 16'h0E);
    chk("midstart_r", c_r, 16'h02);
    @(posedge CLK); #1;

    // Reset in the fourth CALC cycle clears held results and suppresses Done_Sig.
    do_op(0, 16'h9C, 16'd7, q, r, z, lat, tail);
    chk("prerst_q", q, 16'hF2);
    dvd = 100; dvs = 7; start = 3'b001;
    @(posedge CLK); #1;
    start = '0;
    repeat (3) @(posedge CLK);
    @(posedge CLK); #1;
    RST = 1'b1; #1;
    chk("rst_mid_q", c_q, 16'h0);
    chk("rst_mid_r", c_r, 16'h0);
    chk("rst_mid_flags", {13'h0, c_busy, c_done, c_dbz}, 16'h0);
    @(posedge CLK); #1;
    RST = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge CLK); #1;
      if (c_done || c_busy) seen++;
    end
    chk("rst_no_done", 16'(seen), 16'h0);

    // Results hold across idle cycles while operands wander.
    do_op(0, 16'd5, 16'd0, q, r, z, lat, tail);
    bad_hold = 0;
    repeat (20) begin
      @(posedge CLK); #1;
      dvd = 16'($urandom); dvs = 16'($urandom);
      if (c_q !== 16'h00FF || c_r !== 16'h0005 || c_dbz !== 1'b1 || c_done || c_busy)
        bad_hold++;
    end
    chk("hold20", 16'(bad_hold), 16'h0);

    // Start held high restarts every WIDTH+3 cycles.
    sel_r = 0; dvd = 100; dvs = 7; start = 3'b001;
    for (int i = 0; i < 35; i++) begin
      @(posedge CLK); #1;
      if (c_done) held.push_back(i);
    end
    start = '0;
    chk("held_cnt", 16'(held.size()), 16'd3);
    for (int i = 0; i < held.size() && i < 3; i++)
      chk($sformatf("held_done%0d", i), 16'(held[i]), 16'(9 + 11 * i));
    chk("held_q", c_q, 16'h0E);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      if (!c_busy) begin seen = 1; break; end
    end
    chk("held_drain", 16'(seen), 16'h1);

    for (int k = 0; k < 150; k++) begin
      sel = $urandom_range(2);
      w = (sel == 2) ? 16 : 8;
      mask = (w == 16) ? 16'hFFFF : 16'h00FF;
      dvd = 16'($urandom) & mask;
      if ($urandom_range(4) == 0) dvd = 16'(1 << (w - 1));
      case ($urandom_range(7))
        0: dvs = 16'h0;
        1: dvs = mask;
        2: dvs = 16'h1;
        default: dvs = 16'($urandom) & mask;
      endcase
      eq = dvd; er = dvs;
      ref_div(w, sel == 0, eq, er, eq, er, ez);
      do_op(sel, dvd, dvs, q, r, z, lat, tail);
      chk($sformatf("rnd%0d_q", k), q, eq);
      chk($sformatf("rnd%0d_r", k), r, er);
      chk($sformatf("rnd%0d_dbz", k), {15'h0, z}, {15'h0, ez});
      chk($sformatf("rnd%0d_lat", k), 16'(lat), ez ? 16'd1 : 16'(w + 1));
      chk($sformatf("rnd%0d_tail", k), {15'h0, tail}, 16'h1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
